// File: rtl/data_mem_mmio.sv
// Data-side memory: word-addressed RAM plus a small MMIO block (LED, switches,
// cycle counter, compare timer). Reads are combinational from the current state.
module data_mem_mmio #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LED_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WE,
  input  logic [31:0]          WA,
  input  logic [31:0]          WD,
  output logic [31:0]          DataRD,
  input  logic [LED_WIDTH-1:0] SwIn,
  output logic [LED_WIDTH-1:0] LedOut,
  output logic                 TimerIrq
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  localparam logic [3:0] OffLed    = 4'h0;
  localparam logic [3:0] OffSw     = 4'h1;
  localparam logic [3:0] OffCycle  = 4'h2;
  localparam logic [3:0] OffCmp    = 4'h3;
  localparam logic [3:0] OffStat   = 4'h4;
  localparam logic [3:0] OffTcount = 4'h5;

  // Address decode
  logic                  io_sel;
  logic [3:0]            io_off;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  ram_we;
  logic                  wr_led;
  logic                  wr_cmp;
  logic                  wr_stat;

  assign io_sel  = (WA[31:28] == 4'hF);
  assign io_off  = WA[3:0];
  assign ram_idx = WA[ADDR_WIDTH-1:0];
  // A write landing while reset is held is dropped rather than committed.
  assign ram_we  = WE && !io_sel && rst_n;
  assign wr_led  = WE && io_sel && (io_off == OffLed);
  assign wr_cmp  = WE && io_sel && (io_off == OffCmp);
  assign wr_stat = WE && io_sel && (io_off == OffStat);

  logic unused_wa;
  assign unused_wa = ^WA;

  // Data RAM (no reset)
  logic [31:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_idx] <= WD;
    end
  end

  // MMIO state
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [LED_WIDTH-1:0] sw_meta_q, sw_sync_q;
  logic [31:0]          cycle_q, cycle_d;
  logic [31:0]          cmp_q, cmp_d;
  logic [31:0]          tcount_q, tcount_d;
  logic                 match_q, match_d;
  logic                 en_q, en_d;
  logic                 irqen_q, irqen_d;
  logic                 match_hit;

  assign match_hit = en_q && (tcount_q == cmp_q);

  always_comb begin
    led_d    = led_q;
    cmp_d    = cmp_q;
    tcount_d = tcount_q;
    match_d  = match_q;
    en_d     = en_q;
    irqen_d  = irqen_q;
    cycle_d  = cycle_q + 32'd1;

    if (wr_led) begin
      led_d = WD[LED_WIDTH-1:0];
    end

    if (wr_stat) begin
      en_d    = WD[1];
      irqen_d = WD[2];
      if (WD[0]) begin
        match_d = 1'b0;
      end
    end

    // CMP write beats a match; a match beats a write-1-clear of MATCH.
    if (wr_cmp) begin
      cmp_d    = WD;
      tcount_d = '0;
    end else if (match_hit) begin
      tcount_d = '0;
      match_d  = 1'b1;
    end else if (en_q) begin
      tcount_d = tcount_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      cycle_q   <= '0;
      cmp_q     <= 32'hFFFF_FFFF;
      tcount_q  <= '0;
      match_q   <= 1'b0;
      en_q      <= 1'b0;
      irqen_q   <= 1'b0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= SwIn;
      sw_sync_q <= sw_meta_q;
      cycle_q   <= cycle_d;
      cmp_q     <= cmp_d;
      tcount_q  <= tcount_d;
      match_q   <= match_d;
      en_q      <= en_d;
      irqen_q   <= irqen_d;
    end
  end

  // Read path
  logic [31:0] io_rdata;

  always_comb begin
    io_rdata = '0;
    case (io_off)
      OffLed:    io_rdata = 32'(led_q);
      OffSw:     io_rdata = 32'(sw_sync_q);
      OffCycle:  io_rdata = cycle_q;
      OffCmp:    io_rdata = cmp_q;
      OffStat:   io_rdata = {29'd0, irqen_q, en_q, match_q};
      OffTcount: io_rdata = tcount_q;
      default:   io_rdata = '0;
    endcase
  end

  assign DataRD   = io_sel ? io_rdata : mem[ram_idx];
  assign LedOut   = led_q;
  assign TimerIrq = match_q & irqen_q;

endmodule

// File: tb/tb_data_mem_mmio.sv
// Scoreboard bench for data_mem_mmio: each driven access pushes its expected
// DataRD, which is popped and compared once the cycle's read data is stable.
module tb_data_mem_mmio;

  logic        clk;
  logic        rst_n;
  logic        WE;
  logic [31:0] WA;
  logic [31:0] WD;
  logic [31:0] DataRD;
  logic [15:0] SwIn;
  logic [15:0] LedOut;
  logic        TimerIrq;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        chk;
    logic [31:0] exp;
    logic        irq;
  } step_t;

  step_t exp_q[$];

  data_mem_mmio #(
    .ADDR_WIDTH(8),
    .LED_WIDTH (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .WE      (WE),
    .WA      (WA),
    .WD      (WD),
    .DataRD  (DataRD),
    .SwIn    (SwIn),
    .LedOut  (LedOut),
    .TimerIrq(TimerIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t rd(input logic [31:0] a, input logic [31:0] e, input logic irq);
    return '{we: 1'b0, wa: a, wd: 32'h0, chk: 1'b1, exp: e, irq: irq};
  endfunction

  function automatic step_t wr(input logic [31:0] a, input logic [31:0] d, input logic [31:0] e,
                               input logic irq);
    return '{we: 1'b1, wa: a, wd: d, chk: 1'b1, exp: e, irq: irq};
  endfunction

  function automatic step_t wrn(input logic [31:0] a, input logic [31:0] d);
    return '{we: 1'b1, wa: a, wd: d, chk: 1'b0, exp: 32'h0, irq: 1'b0};
  endfunction

  // Each drive applies its inputs for exactly one rising edge.
  task automatic drive(input step_t s);
    @(posedge clk);
    #1;
    WE = s.we;
    WA = s.wa;
    WD = s.wd;
    exp_q.push_back(s);
  endtask

  task automatic test_reset();
    step_t s[7] = '{
      rd(32'hF000_0002, 32'h1, 1'b0),
      rd(32'hF000_0000, 32'h0, 1'b0),
      rd(32'hF000_0001, 32'h0, 1'b0),
      rd(32'hF000_0003, 32'hFFFF_FFFF, 1'b0),
      rd(32'hF000_0004, 32'h0, 1'b0),
      rd(32'hF000_0005, 32'h0, 1'b0),
      rd(32'hF000_0002, 32'h7, 1'b0)
    };
    step_t e;
    checks++;
    if (LedOut !== 16'h0 || TimerIrq !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs led=%h irq=%b expected 0000/0", LedOut, TimerIrq);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp) begin
        errors++;
        $display("FAIL reset[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
      end
    end
  endtask

  task automatic test_ram();
    step_t s[8] = '{
      wrn(32'h0000_0005, 32'hDEAD_BEEF),
      rd(32'h0000_0005, 32'hDEAD_BEEF, 1'b0),
      rd(32'h0000_0105, 32'hDEAD_BEEF, 1'b0),
      rd(32'h0ABC_DE05, 32'hDEAD_BEEF, 1'b0),
      wr(32'h0000_0005, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0),
      rd(32'h0000_0005, 32'h1234_5678, 1'b0),
      wr(32'h0000_0205, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0),
      rd(32'h0000_0005, 32'hDEAD_BEEF, 1'b0)
    };
    step_t e;
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      if (e.chk) begin
        checks++;
        if (DataRD !== e.exp) begin
          errors++;
          $display("FAIL ram[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
        end
      end
    end
  endtask

  task automatic test_led_sw();
    step_t s[5] = '{
      wr(32'hF000_0000, 32'h0001_A5A5, 32'h0, 1'b0),
      rd(32'hF000_0000, 32'h0000_A5A5, 1'b0),
      rd(32'hF000_0001, 32'h0, 1'b0),
      rd(32'hF000_0001, 32'h0000_1234, 1'b0),
      rd(32'hF123_4561, 32'h0000_1234, 1'b0)
    };
    step_t e;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp) begin
        errors++;
        $display("FAIL led_sw[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
      end
      if (i == 1) begin
        SwIn = 16'h1234;
        checks++;
        if (LedOut !== 16'hA5A5) begin
          errors++;
          $display("FAIL led_out LedOut=%04h expected a5a5", LedOut);
        end
      end
    end
  endtask

  task automatic test_timer();
    step_t s[23] = '{
      wr(32'hF000_0003, 32'h3, 32'hFFFF_FFFF, 1'b0),
      wr(32'hF000_0004, 32'h6, 32'h0, 1'b0),
      rd(32'hF000_0005, 32'h0, 1'b0),
      rd(32'hF000_0005, 32'h1, 1'b0),
      rd(32'hF000_0005, 32'h2, 1'b0),
      rd(32'hF000_0005, 32'h3, 1'b0),
      rd(32'hF000_0005, 32'h0, 1'b1),
      rd(32'hF000_0004, 32'h7, 1'b1),
      wr(32'hF000_0004, 32'h7, 32'h7, 1'b1),
      rd(32'hF000_0004, 32'h6, 1'b0),
      rd(32'hF000_0004, 32'h7, 1'b1),
      rd(32'hF000_0005, 32'h1, 1'b1),
      rd(32'hF000_0005, 32'h2, 1'b1),
      wr(32'hF000_0004, 32'h7, 32'h7, 1'b1),
      rd(32'hF000_0004, 32'h7, 1'b1),
      wr(32'hF000_0004, 32'h7, 32'h7, 1'b1),
      rd(32'hF000_0004, 32'h6, 1'b0),
      wr(32'hF000_0003, 32'hA, 32'h3, 1'b0),
      rd(32'hF000_0004, 32'h6, 1'b0),
      rd(32'hF000_0005, 32'h1, 1'b0),
      wr(32'hF000_0004, 32'h0, 32'h6, 1'b0),
      rd(32'hF000_0005, 32'h3, 1'b0),
      rd(32'hF000_0003, 32'hA, 1'b0)
    };
    step_t e;
    for (int i = 0; i < 23; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp) begin
        errors++;
        $display("FAIL timer[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
      end
      checks++;
      if (TimerIrq !== e.irq) begin
        errors++;
        $display("FAIL timer_irq[%0d] TimerIrq=%b expected %b", i, TimerIrq, e.irq);
      end
    end
  endtask

  task automatic test_cycle_wrap();
    step_t s[5] = '{
      rd(32'hF000_0002, 32'hFFFF_FFFE, 1'b0),
      rd(32'hF000_0002, 32'hFFFF_FFFF, 1'b0),
      rd(32'hF000_0002, 32'h0, 1'b0),
      wr(32'hF000_0002, 32'h55, 32'h1, 1'b0),
      rd(32'hF000_0002, 32'h2, 1'b0)
    };
    step_t e;
    for (int i = 0; i < 5; i++) begin
      drive(s[i]);
      if (i == 0) begin
        force dut.cycle_q = 32'hFFFF_FFFE;
        #1;
        release dut.cycle_q;
      end
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp) begin
        errors++;
        $display("FAIL cycle[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
      end
    end
  endtask

  task automatic test_unmapped();
    step_t s[8] = '{
      rd(32'hF000_000A, 32'h0, 1'b0),
      rd(32'hF000_0005, 32'h3, 1'b0),
      wr(32'hF000_0005, 32'h0, 32'h3, 1'b0),
      rd(32'hF000_0005, 32'h3, 1'b0),
      rd(32'h0000_0005, 32'hDEAD_BEEF, 1'b0),
      wr(32'hF000_0009, 32'hFFFF_FFFF, 32'h0, 1'b0),
      rd(32'hF000_0009, 32'h0, 1'b0),
      rd(32'hF000_0004, 32'h0, 1'b0)
    };
    step_t e;
    for (int i = 0; i < 8; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp) begin
        errors++;
        $display("FAIL unmapped[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t s[4] = '{
      wr(32'hF000_0003, 32'h0, 32'hA, 1'b0),
      wr(32'hF000_0004, 32'h6, 32'h0, 1'b0),
      rd(32'hF000_0004, 32'h6, 1'b0),
      rd(32'hF000_0004, 32'h7, 1'b1)
    };
    step_t post[2] = '{
      rd(32'h0000_0005, 32'hDEAD_BEEF, 1'b0),
      rd(32'hF000_0002, 32'h2, 1'b0)
    };
    step_t e;
    logic [31:0] io_addr[3] = '{32'hF000_0004, 32'hF000_0003, 32'hF000_0000};
    logic [31:0] io_exp[3]  = '{32'h0, 32'hFFFF_FFFF, 32'h0};
    for (int i = 0; i < 4; i++) begin
      drive(s[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp || TimerIrq !== e.irq) begin
        errors++;
        $display("FAIL arst_pre[%0d] DataRD=%08h irq=%b expected %08h/%b", i, DataRD, TimerIrq,
                 e.exp, e.irq);
      end
    end
    // Assert reset between edges while a RAM write is pending.
    @(posedge clk);
    #1;
    WE = 1'b1;
    WA = 32'h0000_0005;
    WD = 32'h0BAD_0BAD;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (LedOut !== 16'h0 || TimerIrq !== 1'b0) begin
      errors++;
      $display("FAIL arst_outputs led=%h irq=%b expected 0000/0", LedOut, TimerIrq);
    end
    WE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WA = io_addr[i];
      #1;
      checks++;
      if (DataRD !== io_exp[i]) begin
        errors++;
        $display("FAIL arst_io[%0d] DataRD=%08h expected %08h", i, DataRD, io_exp[i]);
      end
    end
    WE = 1'b1;
    WA = 32'h0000_0005;
    WD = 32'h0BAD_0BAD;
    @(posedge clk);
    @(negedge clk);
    WE = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(post[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (DataRD !== e.exp) begin
        errors++;
        $display("FAIL arst_post[%0d] DataRD=%08h expected %08h", i, DataRD, e.exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    WE    = 1'b0;
    WA    = 32'h0;
    WD    = 32'h0;
    SwIn  = 16'h0;
    repeat (3) @(negedge clk);
    test_reset();
    test_ram();
    test_led_sw();
    test_timer();
    test_cycle_wrap();
    test_unmapped();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
